// File: rtl/strobe_record_gen_pkg.sv
// Shared record field offsets, FSM state encoding and record packing helper
// for the strobe timestamping front end.
package strobe_record_gen_pkg;

    localparam int NUM_CH         = 4;
    localparam int REC_W          = 47;
    localparam int REC_WRAP_BIT   = 46;
    localparam int REC_STROBE_LSB = 42;
    localparam int REC_DELTA_LSB  = 38;
    localparam int REC_TS_LSB     = 0;
    localparam int REC_TS_W       = 38;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    function automatic logic [REC_W-1:0] make_record(
        input logic                wrap,
        input logic [NUM_CH-1:0]   chs,
        input logic [NUM_CH-1:0]   delta,
        input logic [REC_TS_W-1:0] ts
    );
        logic [REC_W-1:0] r;
        r = '0;
        r[REC_WRAP_BIT]               = wrap;
        r[REC_STROBE_LSB +: NUM_CH]   = chs;
        r[REC_DELTA_LSB +: NUM_CH]    = delta;
        r[REC_TS_LSB +: REC_TS_W]     = ts;
        return r;
    endfunction

endpackage

// File: rtl/strobe_record_gen_edge_sync.sv
// One strobe channel: input synchroniser, rising-edge detect and, when
// STROBE_DEADTIME_EN is defined, a per-channel holdoff counter.
module strobe_edge_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int DEADTIME    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic strobe_in,
    input  logic ch_enable,
    input  logic clr,
    output logic edge_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   raw_edge;

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], strobe_in};
        prev_d   = sync_q[SYNC_STAGES-1];
        raw_edge = sync_q[SYNC_STAGES-1] & ~prev_q & ch_enable;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

`ifdef STROBE_DEADTIME_EN
    localparam int DT_W = $clog2(DEADTIME + 1);

    logic [DT_W-1:0] dt_q, dt_d;

    // Start clears the holdoff even if an edge arrives in the same cycle.
    always_comb begin
        edge_o = raw_edge & (dt_q == '0);
        if (clr)
            dt_d = '0;
        else if (edge_o)
            dt_d = DT_W'(DEADTIME);
        else if (dt_q != '0)
            dt_d = dt_q - DT_W'(1);
        else
            dt_d = dt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            dt_q <= '0;
        else
            dt_q <= dt_d;
    end
`else
    logic unused_cfg;

    assign unused_cfg = clr | (DEADTIME > 0);
    assign edge_o     = raw_edge;
`endif

endmodule

// File: rtl/strobe_record_gen.sv
// Timestamps strobe edges against a free-running timer and emits 47-bit records,
// plus wrap markers. Optional holdoff per channel via STROBE_DEADTIME_EN.
module strobe_record_gen
    import strobe_record_gen_pkg::*;
#(
    parameter int TS_WIDTH    = 38,
    parameter int SYNC_STAGES = 2,
    parameter int DEADTIME    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] strobe_in,
    input  logic [NUM_CH-1:0] delta_in,
    input  logic [NUM_CH-1:0] ch_enable,
    input  logic              acq_start,
    input  logic              acq_stop,
    output logic              running,
    output logic              record_rdy,
    output logic [REC_W-1:0]  record
);

    state_t                state_q, state_d;
    logic [TS_WIDTH-1:0]   timer_q, timer_d;
    logic                  pending_wrap_q, pending_wrap_d;
    logic                  record_rdy_q, record_rdy_d;
    logic [REC_W-1:0]      record_q, record_d;

    logic [NUM_CH-1:0]     edge_vec;
    logic [REC_TS_W-1:0]   ts_ext;
    logic                  timer_max;
    logic [REC_W-1:0]      marker_rec;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        strobe_edge_sync #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEADTIME    (DEADTIME)
        ) u_sync (
            .clk       (clk),
            .rst       (reset),
            .strobe_in (strobe_in[i]),
            .ch_enable (ch_enable[i]),
            .clr       (acq_start),
            .edge_o    (edge_vec[i])
        );
    end

    always_comb begin
        ts_ext               = '0;
        ts_ext[TS_WIDTH-1:0] = timer_q;
        timer_max            = &timer_q;
        marker_rec           = make_record(1'b1, '0, delta_in, '0);
    end

    always_comb begin
        state_d        = state_q;
        timer_d        = timer_q;
        pending_wrap_d = pending_wrap_q;
        record_rdy_d   = 1'b0;
        record_d       = record_q;
        case (state_q)
            ST_IDLE: begin
                if (acq_start && !acq_stop) begin
                    state_d        = ST_RUN;
                    timer_d        = '0;
                    pending_wrap_d = 1'b0;
                end
            end
            ST_RUN: begin
                timer_d = timer_q + TS_WIDTH'(1);
                // Edges always take the slot; the marker waits, and in the stop cycle it goes to FLUSH.
                if (|edge_vec) begin
                    record_rdy_d = 1'b1;
                    record_d     = make_record(1'b0, edge_vec, delta_in, ts_ext);
                end else if (pending_wrap_q && !acq_stop) begin
                    record_rdy_d   = 1'b1;
                    record_d       = marker_rec;
                    pending_wrap_d = 1'b0;
                end
                if (timer_max)
                    pending_wrap_d = 1'b1;
                if (acq_stop) begin
                    state_d = (pending_wrap_q || timer_max) ? ST_FLUSH : ST_IDLE;
                end else if (acq_start) begin
                    timer_d        = '0;
                    pending_wrap_d = 1'b0;
                end
            end
            ST_FLUSH: begin
                record_rdy_d   = 1'b1;
                record_d       = marker_rec;
                pending_wrap_d = 1'b0;
                state_d        = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            timer_q        <= '0;
            pending_wrap_q <= 1'b0;
            record_rdy_q   <= 1'b0;
            record_q       <= '0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            pending_wrap_q <= pending_wrap_d;
            record_rdy_q   <= record_rdy_d;
            record_q       <= record_d;
        end
    end

    assign running    = (state_q == ST_RUN);
    assign record_rdy = record_rdy_q;
    assign record     = record_q;

endmodule

// File: tb/tb_strobe_record_gen.sv
// Self-checking bench for strobe_record_gen (TS_WIDTH=8 so the timer wraps quickly),
// directed scenarios followed by random stimulus against a cycle-indexed reference model.
module tb_strobe_record_gen;

    localparam int TS_W  = 8;
    localparam int DT    = 8;
    localparam int MAXC  = 4096;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  strobe_in = '0;
    logic [3:0]  delta_in = '0;
    logic [3:0]  ch_enable = 4'hF;
    logic        acq_start = 1'b0;
    logic        acq_stop = 1'b0;
    logic        running;
    logic        record_rdy;
    logic [46:0] record;

    strobe_record_gen #(
        .TS_WIDTH    (TS_W),
        .SYNC_STAGES (2),
        .DEADTIME    (DT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .strobe_in  (strobe_in),
        .delta_in   (delta_in),
        .ch_enable  (ch_enable),
        .acq_start  (acq_start),
        .acq_stop   (acq_stop),
        .running    (running),
        .record_rdy (record_rdy),
        .record     (record)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int n_rec = 0;
    int last_cyc = -1;
    logic [46:0] last_rec = '0;
    logic [3:0]  cur_en = 4'hF;

    // Reference model: pin history by cycle, acquisition mode flags, integer timer.
    logic [3:0]  pin_at [MAXC];
    int          last_acc [4];
    bit          m_run, m_flush, m_pend;
    int          m_timer;
    logic        exp_rdy, exp_run;
    logic [46:0] exp_rec;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    function automatic logic [3:0] pin(input int k);
        return (k < 0 || k >= MAXC) ? 4'h0 : pin_at[k];
    endfunction

    task automatic model_reset();
        m_run = 0; m_flush = 0; m_pend = 0; m_timer = 0;
        exp_rdy = 0; exp_run = 0; exp_rec = '0;
        for (int i = 0; i < 4; i++) last_acc[i] = -1000;
    endtask

    task automatic model_step(input logic [3:0] d, input logic st, input logic sp);
        logic [3:0]  ed;
        logic [46:0] marker;
        bit          wrap;
        for (int i = 0; i < 4; i++) begin
            ed[i] = pin(cyc - 2)[i] & ~pin(cyc - 3)[i] & cur_en[i];
`ifdef STROBE_DEADTIME_EN
            if (cyc - last_acc[i] <= DT) ed[i] = 1'b0;
            if (ed[i]) last_acc[i] = cyc;
`endif
        end
        if (st) for (int i = 0; i < 4; i++) last_acc[i] = -1000;
        marker  = {1'b1, 4'b0, d, 38'b0};
        exp_rdy = 1'b0;
        if (m_run) begin
            wrap = (m_timer == (1 << TS_W) - 1);
            if (ed != 0) begin
                exp_rdy = 1'b1;
                exp_rec = {1'b0, ed, d, 38'(m_timer)};
            end else if (m_pend && !sp) begin
                exp_rdy = 1'b1;
                exp_rec = marker;
                m_pend  = 0;
            end
            if (wrap) m_pend = 1;
            m_timer = (m_timer + 1) % (1 << TS_W);
            if (sp) begin
                m_run   = 0;
                m_flush = m_pend;
            end else if (st) begin
                m_timer = 0;
                m_pend  = 0;
            end
        end else if (m_flush) begin
            exp_rdy = 1'b1;
            exp_rec = marker;
            m_pend  = 0;
            m_flush = 0;
        end else if (st && !sp) begin
            m_run   = 1;
            m_timer = 0;
            m_pend  = 0;
        end
        exp_run = m_run;
    endtask

    task automatic step(input logic [3:0] s, input logic st, input logic sp);
        logic [3:0] d;
        @(posedge clk);
        cyc++;
        #1;
        chk("rdy", record_rdy, exp_rdy);
        chk("record", record, exp_rec);
        chk("running", running, exp_run);
        if (record_rdy) begin
            n_rec++;
            last_cyc = cyc;
            last_rec = record;
        end
        d         = 4'($urandom);
        strobe_in = s;
        delta_in  = d;
        ch_enable = cur_en;
        acq_start = st;
        acq_stop  = sp;
        if (cyc < MAXC) pin_at[cyc] = s;
        model_step(d, st, sp);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1; strobe_in = '0; acq_start = 1'b0; acq_stop = 1'b0;
        #1;
        chk("rst_rdy", record_rdy, 1'b0);
        chk("rst_record", record, 47'b0);
        chk("rst_running", running, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        cyc = 0;
        pin_at[0] = '0;
        model_reset();
    endtask

    initial begin
        int base, cnt;
        logic [3:0] s;
        model_reset();
        do_reset();

        // Single edge on ch0 with start at cycle 10
        for (int c = 1; c <= 25; c++) step((c == 20) ? 4'h1 : 4'h0, c == 10, 1'b0);
        chk("t1_cycle", last_cyc, 23);
        chk("t1_chs", last_rec[45:42], 4'b0001);
        chk("t1_ts", last_rec[37:0], 11);

        // Simultaneous edges on ch1 and ch3
        cnt = n_rec;
        for (int j = 1; j <= 8; j++) step((j == 2) ? 4'b1010 : 4'h0, 1'b0, 1'b0);
        chk("t2_count", n_rec - cnt, 1);
        chk("t2_chs", last_rec[45:42], 4'b1010);

        // Disabled channel
        cur_en = 4'b1110;
        cnt = n_rec;
        for (int j = 1; j <= 8; j++) step((j == 2) ? 4'h1 : 4'h0, 1'b0, 1'b0);
        chk("t3_count", n_rec - cnt, 0);
        cur_en = 4'hF;

        // Edge detected exactly at the wrap, then deferred marker
        step(4'h0, 1'b1, 1'b0);
        base = cyc;
        for (int j = 1; j <= 262; j++) begin
            step((j == 255) ? 4'h1 : 4'h0, 1'b0, 1'b0);
            if (j == 258) begin
                chk("t4_cycle", last_cyc, base + 258);
                chk("t4_ts", last_rec[37:0], 0);
                chk("t4_chs", last_rec[46:42], 5'b00001);
            end
            if (j == 259) begin
                chk("t4_marker", last_rec[46], 1'b1);
                chk("t4_mcycle", last_cyc, base + 259);
            end
        end

        // Stop while a wrap is pending: FLUSH marker, then idle ignores edges
        step(4'h0, 1'b1, 1'b0);
        base = cyc;
        for (int j = 1; j <= 258; j++) step(4'h0, 1'b0, j == 256);
        chk("t5_marker", last_rec[46], 1'b1);
        chk("t5_cycle", last_cyc, base + 258);
        chk("t5_running", running, 1'b0);
        cnt = n_rec;
        for (int j = 1; j <= 10; j++) step((j == 3) ? 4'hF : 4'h0, 1'b0, 1'b0);
        chk("t5_idle_count", n_rec - cnt, 0);

        // Holdoff: ch2 edges 4 and 9 cycles apart
        step(4'h0, 1'b1, 1'b0);
        cnt = n_rec;
        for (int j = 1; j <= 20; j++)
            step((j == 3 || j == 7 || j == 12) ? 4'b0100 : 4'h0, 1'b0, 1'b0);
`ifdef STROBE_DEADTIME_EN
        chk("t6_count", n_rec - cnt, 2);
`else
        chk("t6_count", n_rec - cnt, 3);
`endif

        // Reset in the middle of an acquisition with edges in flight
        for (int j = 1; j <= 6; j++) step((j == 4) ? 4'h3 : 4'h0, 1'b0, 1'b0);
        do_reset();

        for (int k = 0; k < 1500; k++) begin
            s = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 99) == 0) cur_en = 4'($urandom);
            step(s, $urandom_range(0, 199) == 0, $urandom_range(0, 299) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
